// File: rtl/volume_control_object.sv
// Volume control object: debounced-free key handling with 2-FF synchronisers,
// saturating volume level, frame-synchronous display shadow, title rectangle
// offsets (latency 1) and segmented volume bar (latency 2).
// Optional macro VOLUME_AUTOREPEAT_EN enables frame-based key auto-repeat.
module volume_control_object #(
  parameter logic [10:0] TOP_LEFT_X  = 11'd256,
  parameter logic [10:0] TOP_LEFT_Y  = 11'd16,
  parameter logic [7:0]  BAR_COLOR   = 8'h1C,
  parameter logic [3:0]  LEVEL_RESET = 4'd8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        volUpKey,
  input  logic        volDownKey,
  output logic [10:0] titleOffsetX,
  output logic [10:0] titleOffsetY,
  output logic        titleInside,
  output logic        barDrawingRequest,
  output logic [7:0]  barRGB,
  output logic [3:0]  volumeLevel
);

  // 12-bit bounds so that edges near the top of the 11-bit range cannot wrap
  localparam logic [11:0] X_END  = {1'b0, TOP_LEFT_X} + 12'd128;
  localparam logic [11:0] Y_END  = {1'b0, TOP_LEFT_Y} + 12'd16;
  localparam logic [11:0] BAR_Y0 = {1'b0, TOP_LEFT_Y} + 12'd20;
  localparam logic [11:0] BAR_Y1 = {1'b0, TOP_LEFT_Y} + 12'd28;

  // bit 0 = up key, bit 1 = down key
  logic [1:0] sync0, sync1, prev, armed, settle;
  logic [1:0] press_evt, rep_evt, key_evt;
  logic [3:0] displayLevel;

  // Key synchronisers and edge detectors. A key is armed only after it has been
  // seen released once the synchroniser holds valid data, so a key held across
  // reset release produces no event until it is released and pressed again.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync0  <= '0;
      sync1  <= '0;
      prev   <= '0;
      armed  <= '0;
      settle <= '0;
    end else begin
      sync0  <= {volDownKey, volUpKey};
      sync1  <= sync0;
      prev   <= sync1;
      settle <= {settle[0], 1'b1};
      armed  <= armed | ({2{settle[1]}} & ~sync1);
    end
  end

  assign press_evt = sync1 & ~prev & armed;

`ifdef VOLUME_AUTOREPEAT_EN
  logic [1:0]      held;
  logic [1:0]      rep_phase;
  logic [1:0][4:0] rep_cnt;

  assign held = sync1 & prev & armed;

  // Repeat event on the 30th frame pulse of a hold, then on every 8th
  always_comb begin
    rep_evt = '0;
    for (int unsigned k = 0; k < 2; k++)
      rep_evt[k] = startOfFrame && held[k] &&
                   (rep_cnt[k] == (rep_phase[k] ? 5'd7 : 5'd29));
  end

  // Per-key frame counters, cleared whenever the key is not held
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rep_cnt   <= '0;
      rep_phase <= '0;
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (!held[k]) begin
          rep_cnt[k]   <= '0;
          rep_phase[k] <= 1'b0;
        end else if (startOfFrame) begin
          if (rep_evt[k]) begin
            rep_cnt[k]   <= '0;
            rep_phase[k] <= 1'b1;
          end else begin
            rep_cnt[k] <= rep_cnt[k] + 5'd1;
          end
        end
      end
    end
  end
`else
  assign rep_evt = '0;
`endif

  assign key_evt = press_evt | rep_evt;

  // Saturating volume level; simultaneous up/down events cancel
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      volumeLevel <= LEVEL_RESET;
    end else if (key_evt[0] && !key_evt[1] && volumeLevel != 4'd15) begin
      volumeLevel <= volumeLevel + 4'd1;
    end else if (key_evt[1] && !key_evt[0] && volumeLevel != 4'd0) begin
      volumeLevel <= volumeLevel - 4'd1;
    end
  end

  // Display shadow updated only at frame start to avoid bar tearing
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)           displayLevel <= LEVEL_RESET;
    else if (startOfFrame) displayLevel <= volumeLevel;
  end

  logic [10:0] x_rel, y_rel;
  logic        in_x, in_title, in_bar, lit;

  // Region decode and bar segment lighting
  always_comb begin
    x_rel    = pixelX - TOP_LEFT_X;
    y_rel    = pixelY - TOP_LEFT_Y;
    in_x     = (pixelX >= TOP_LEFT_X) && ({1'b0, pixelX} < X_END);
    in_title = in_x && (pixelY >= TOP_LEFT_Y) && ({1'b0, pixelY} < Y_END);
    in_bar   = in_x && ({1'b0, pixelY} >= BAR_Y0) && ({1'b0, pixelY} < BAR_Y1);
    lit      = in_bar && (x_rel[6:3] < displayLevel) && (x_rel[2:0] != 3'd7);
  end

  logic lit_q;

  // Title outputs (latency 1) and bar pipeline (latency 2)
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      titleInside       <= 1'b0;
      titleOffsetX      <= '0;
      titleOffsetY      <= '0;
      lit_q             <= 1'b0;
      barDrawingRequest <= 1'b0;
      barRGB            <= 8'h00;
    end else begin
      titleInside       <= in_title;
      titleOffsetX      <= in_title ? x_rel : '0;
      titleOffsetY      <= in_title ? y_rel : '0;
      lit_q             <= lit;
      barDrawingRequest <= lit_q;
      barRGB            <= lit_q ? BAR_COLOR : 8'h00;
    end
  end

endmodule

// File: tb/tb_volume_control_object.sv
// Directed testbench for volume_control_object.
module tb_volume_control_object;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, volUpKey, volDownKey;
  logic [10:0] titleOffsetX, titleOffsetY;
  logic        titleInside, barDrawingRequest;
  logic [7:0]  barRGB;
  logic [3:0]  volumeLevel;

  int total = 0;
  int bad   = 0;

  volume_control_object dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .volUpKey(volUpKey), .volDownKey(volDownKey),
    .titleOffsetX(titleOffsetX), .titleOffsetY(titleOffsetY),
    .titleInside(titleInside), .barDrawingRequest(barDrawingRequest),
    .barRGB(barRGB), .volumeLevel(volumeLevel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] px;
    logic [10:0] py;
    logic        ins;
    logic [10:0] ox;
    logic [10:0] oy;
    logic [7:0]  rgb;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic up, input logic dn);
    volUpKey = up; volDownKey = dn;
    repeat (4) tick();
    volUpKey = 1'b0; volDownKey = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic check_bar(input string name, input int x, input int y, input int exp_rgb);
    pixelX = 11'(x); pixelY = 11'(y);
    tick(); tick();
    check({name, "_rgb"}, barRGB, exp_rgb);
    check({name, "_req"}, barDrawingRequest, exp_rgb != 0);
  endtask

  initial begin
    // px, py, inside, offX, offY, barRGB (displayLevel = 3)
    vecs[0]  = '{11'd256, 11'd16, 1'b1, 11'd0,   11'd0,  8'h00};
    vecs[1]  = '{11'd383, 11'd31, 1'b1, 11'd127, 11'd15, 8'h00};
    vecs[2]  = '{11'd384, 11'd31, 1'b0, 11'd0,   11'd0,  8'h00};
    vecs[3]  = '{11'd255, 11'd16, 1'b0, 11'd0,   11'd0,  8'h00};
    vecs[4]  = '{11'd256, 11'd15, 1'b0, 11'd0,   11'd0,  8'h00};
    vecs[5]  = '{11'd278, 11'd40, 1'b0, 11'd0,   11'd0,  8'h1C};
    vecs[6]  = '{11'd279, 11'd40, 1'b0, 11'd0,   11'd0,  8'h00};
    vecs[7]  = '{11'd263, 11'd40, 1'b0, 11'd0,   11'd0,  8'h00};
    vecs[8]  = '{11'd280, 11'd40, 1'b0, 11'd0,   11'd0,  8'h00};
    vecs[9]  = '{11'd256, 11'd36, 1'b0, 11'd0,   11'd0,  8'h1C};
    vecs[10] = '{11'd256, 11'd43, 1'b0, 11'd0,   11'd0,  8'h1C};
    vecs[11] = '{11'd256, 11'd44, 1'b0, 11'd0,   11'd0,  8'h00};
    vecs[12] = '{11'd256, 11'd35, 1'b0, 11'd0,   11'd0,  8'h00};
    vecs[13] = '{11'd255, 11'd40, 1'b0, 11'd0,   11'd0,  8'h00};
    vecs[14] = '{11'd262, 11'd40, 1'b0, 11'd0,   11'd0,  8'h1C};

    resetN = 1'b0; pixelX = '0; pixelY = '0;
    startOfFrame = 1'b0; volUpKey = 1'b0; volDownKey = 1'b0;
    repeat (3) tick();
    check("rst_level", volumeLevel, 8);
    check("rst_inside", titleInside, 0);
    check("rst_offx", titleOffsetX, 0);
    check("rst_offy", titleOffsetY, 0);
    check("rst_barreq", barDrawingRequest, 0);
    check("rst_rgb", barRGB, 0);
    resetN = 1'b1;
    repeat (4) tick();

    // press latency: level changes on the third edge after the key rises
    volUpKey = 1'b1;
    tick(); tick();
    check("lat_before", volumeLevel, 8);
    tick();
    check("lat_after", volumeLevel, 9);
    tick();
    volUpKey = 1'b0;
    repeat (4) tick();
    press(1, 0); press(1, 0);
    check("up3", volumeLevel, 11);

    // segment 10 dark while displayLevel still 8, lit after frame start
    check_bar("disp_old", 336, 40, 8'h00);
    frame_pulse();
    check_bar("disp_new", 336, 40, 8'h1C);

    repeat (4) press(1, 0);
    check("up15", volumeLevel, 15);
    press(1, 0);
    check("sat15", volumeLevel, 15);
    frame_pulse();
    check_bar("lvl15_seg14", 368, 40, 8'h1C);
    check_bar("lvl15_seg15", 376, 40, 8'h00);

    repeat (16) press(0, 1);
    check("down0", volumeLevel, 0);
    press(0, 1);
    check("sat0", volumeLevel, 0);
    frame_pulse();
    check_bar("lvl0_seg0", 256, 40, 8'h00);

    repeat (3) press(1, 0);
    check("up_to3", volumeLevel, 3);
    frame_pulse();
    for (int i = 0; i < 15; i++) begin
      pixelX = vecs[i].px; pixelY = vecs[i].py;
      tick();
      check($sformatf("v%0d_inside", i), titleInside, vecs[i].ins);
      check($sformatf("v%0d_offx", i), titleOffsetX, vecs[i].ox);
      check($sformatf("v%0d_offy", i), titleOffsetY, vecs[i].oy);
      tick();
      check($sformatf("v%0d_rgb", i), barRGB, vecs[i].rgb);
      check($sformatf("v%0d_req", i), barDrawingRequest, vecs[i].rgb != 8'h00);
    end

    press(1, 1);
    check("both_keys", volumeLevel, 3);

    // reset during a hold, key still held at release
    volUpKey = 1'b1;
    repeat (2) tick();
    resetN = 1'b0;
    #1;
    check("mid_rst_async", volumeLevel, 8);
    tick();
    resetN = 1'b1;
    repeat (10) tick();
    check("held_after_rst", volumeLevel, 8);
    volUpKey = 1'b0;
    repeat (4) tick();
    press(1, 0);
    check("repress", volumeLevel, 9);

    // hold up for 46 frames from level 0
    repeat (9) press(0, 1);
    check("pre_hold0", volumeLevel, 0);
    volUpKey = 1'b1;
    repeat (4) tick();
    for (int i = 1; i <= 46; i++) begin
      frame_pulse();
      tick(); tick();
`ifdef VOLUME_AUTOREPEAT_EN
      if (i == 29) check("hold_f29", volumeLevel, 1);
      if (i == 30) check("hold_f30", volumeLevel, 2);
      if (i == 38) check("hold_f38", volumeLevel, 3);
`else
      if (i == 30) check("hold_f30", volumeLevel, 1);
`endif
    end
    volUpKey = 1'b0;
    repeat (4) tick();
`ifdef VOLUME_AUTOREPEAT_EN
    check("hold_46", volumeLevel, 4);
`else
    check("hold_46", volumeLevel, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
